ntt_butterfly: RTL and testbench

- Pipelined radix-2 butterfly for the Kyber NTT/INTT datapath, q = 3329.
- Accepts one coefficient pair and twiddle per cycle and performs either a Cooley-Tukey (NTT) or Gentleman-Sande (INTT) butterfly.
- Instantiates mo_mul for the twiddle product and consumes its signed (-Q,Q) result.
- Emits canonical [0,Q) coefficients to the polynomial RAM write port, with a tag passed through for write-address alignment.

---
 rtl/ntt_butterfly.sv | 181 ++++++++++++++++++
 tb/tb_ntt_butterfly.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ntt_butterfly.sv
`default_nettype none
// ============================================================================
// Module : mo_mul / ntt_butterfly
// Brief  : Montgomery multiplier and pipelined Kyber CT/GS butterfly
// Rev    : 1.0
// ============================================================================

module mo_mul #(
  parameter int W      = 12,
  parameter int Q      = 3329,
  parameter int STAGES = 12
) (
  input  logic         clk,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W+1:0] t
);

  // Newton iteration for Q^-1 mod 2^W; each step doubles the correct low bits.
  function automatic logic [W-1:0] calc_qinv();
    logic [W-1:0] x;
    x = W'(Q);
    for (int i = 0; i < 6; i++) x = x * (W'(2) - W'(Q) * x);
    return x;
  endfunction

  localparam int PW = 2 * W + 2;
  localparam logic [W-1:0]        c_qinv = calc_qinv();
  localparam logic signed [W+1:0] c_q_x  = (W + 2)'(Q);
  localparam logic signed [PW-1:0] c_q_p = PW'(Q);

  logic [2*W-1:0]        r_prod1;
  logic [2*W-1:0]        r_prod2;
  logic [W-1:0]          r_m2;
  logic signed [W+1:0]   r_t3;
  logic [W-1:0]          w_m;
  logic signed [PW-1:0]  w_diff;
  logic signed [W+1:0]   w_red;
  logic signed [W+1:0]   w_t;
  logic                  unused_low;

  // prod - m*Q is an exact multiple of 2^W, so the quotient is just the top bits.
  always_comb begin
    w_m    = r_prod1[W-1:0] * c_qinv;
    w_diff = $signed({2'b00, r_prod2}) - PW'($signed(r_m2)) * c_q_p;
    w_red  = $signed(w_diff[PW-1:W]);
    w_t    = (w_red >= c_q_x) ? w_red - c_q_x : w_red;
  end

  assign unused_low = ^w_diff[W-1:0];

  always_ff @(posedge clk) begin
    r_prod1 <= (2 * W)'(a) * (2 * W)'(b);
    r_prod2 <= r_prod1;
    r_m2    <= w_m;
    r_t3    <= w_t;
  end

  generate
    if (STAGES > 3) begin : g_pad
      logic [W+1:0] r_pad [STAGES-3];
      always_ff @(posedge clk) begin
        r_pad[0] <= r_t3;
        for (int i = 1; i < STAGES - 3; i++) r_pad[i] <= r_pad[i-1];
      end
      assign t = r_pad[STAGES-4];
    end else begin : g_nopad
      assign t = r_t3;
    end
  endgenerate

endmodule

module ntt_butterfly #(
  parameter int MUL_STAGE_CNT = 12,
  parameter int Q             = 3329,
  parameter int TAG_W         = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_mode,
  input  logic [MUL_STAGE_CNT-1:0] in_u,
  input  logic [MUL_STAGE_CNT-1:0] in_v,
  input  logic [MUL_STAGE_CNT-1:0] in_w,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  output logic [MUL_STAGE_CNT-1:0] out_u,
  output logic [MUL_STAGE_CNT-1:0] out_v,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int W  = MUL_STAGE_CNT;
  localparam int XW = W + 2;
  localparam logic signed [XW-1:0] c_q_x = XW'(Q);

  logic signed [XW-1:0] w_u_x, w_v_x, w_sum, w_dif;
  logic [W-1:0]         w_mul_a, w_p;
  logic [XW-1:0]        w_t_raw;
  logic signed [XW-1:0] w_t_x, w_p_x, w_ct_u, w_ct_v, w_gs_v;
  logic [W-1:0]         w_nxt_u, w_nxt_v;
  logic                 unused_hi;

  logic [W-1:0]         r_dl_valid;
  logic [W-1:0]         r_dl_mode;
  logic [TAG_W-1:0]     r_dl_tag [W];
  logic [W-1:0]         r_dl_p   [W];

  always_comb begin
    w_u_x = $signed({2'b00, in_u});
    w_v_x = $signed({2'b00, in_v});
    w_sum = w_u_x + w_v_x;
    if (w_sum >= c_q_x) w_sum = w_sum - c_q_x;
    w_dif = w_u_x - w_v_x;
    if (w_dif[XW-1]) w_dif = w_dif + c_q_x;
    w_mul_a = in_mode ? w_dif[W-1:0] : in_v;
    w_p     = in_mode ? w_sum[W-1:0] : in_u;
  end

  mo_mul #(
    .W      (W),
    .Q      (Q),
    .STAGES (MUL_STAGE_CNT)
  ) u_mo_mul (
    .clk (clk),
    .a   (w_mul_a),
    .b   (in_w),
    .t   (w_t_raw)
  );

  // Only the valid bits are cleared; stale data behind a 0 valid is never emitted.
  always_ff @(posedge clk) begin
    if (rst) r_dl_valid <= '0;
    else     r_dl_valid <= {r_dl_valid[W-2:0], in_valid};
  end

  always_ff @(posedge clk) begin
    r_dl_mode   <= {r_dl_mode[W-2:0], in_mode};
    r_dl_tag[0] <= in_tag;
    r_dl_p[0]   <= w_p;
    for (int i = 1; i < W; i++) begin
      r_dl_tag[i] <= r_dl_tag[i-1];
      r_dl_p[i]   <= r_dl_p[i-1];
    end
  end

  always_comb begin
    w_t_x  = $signed(w_t_raw);
    w_p_x  = $signed({2'b00, r_dl_p[W-1]});
    w_ct_u = w_p_x + w_t_x;
    if (w_ct_u[XW-1])          w_ct_u = w_ct_u + c_q_x;
    else if (w_ct_u >= c_q_x)  w_ct_u = w_ct_u - c_q_x;
    w_ct_v = w_p_x - w_t_x;
    if (w_ct_v[XW-1])          w_ct_v = w_ct_v + c_q_x;
    else if (w_ct_v >= c_q_x)  w_ct_v = w_ct_v - c_q_x;
    w_gs_v  = w_t_x[XW-1] ? w_t_x + c_q_x : w_t_x;
    w_nxt_u = r_dl_mode[W-1] ? r_dl_p[W-1]   : w_ct_u[W-1:0];
    w_nxt_v = r_dl_mode[W-1] ? w_gs_v[W-1:0] : w_ct_v[W-1:0];
  end

  assign unused_hi = ^{w_sum[XW-1:W], w_dif[XW-1:W], w_ct_u[XW-1:W],
                       w_ct_v[XW-1:W], w_gs_v[XW-1:W]};

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_u     <= '0;
      out_v     <= '0;
      out_tag   <= '0;
    end else begin
      out_valid <= r_dl_valid[W-1];
      if (r_dl_valid[W-1]) begin
        out_u   <= w_nxt_u;
        out_v   <= w_nxt_v;
        out_tag <= r_dl_tag[W-1];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ntt_butterfly.sv
`default_nettype none
// ============================================================================
// Module : tb_ntt_butterfly
// Brief  : Scoreboard bench for ntt_butterfly (directed vectors + stream)
// Rev    : 1.0
// ============================================================================
module tb_ntt_butterfly;
  localparam int W   = 12;
  localparam int Q   = 3329;
  localparam int TW  = 8;
  localparam int LAT = 13;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_mode = 1'b0;
  logic [W-1:0]  in_u = '0, in_v = '0, in_w = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic [W-1:0]  out_u, out_v;
  logic [TW-1:0] out_tag;

  ntt_butterfly #(.MUL_STAGE_CNT(W), .Q(Q), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_mode(in_mode),
    .in_u(in_u), .in_v(in_v), .in_w(in_w), .in_tag(in_tag),
    .out_valid(out_valid), .out_u(out_u), .out_v(out_v), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_seen = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  typedef struct {int u; int v; int tag; int at;} exp_t;
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   rinv   = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void model(input bit m, input int u, input int v, input int w,
                                output int eu, output int ev);
    int wt, t;
    wt = (w * rinv) % Q;
    if (!m) begin
      t  = (v * wt) % Q;
      eu = (u + t) % Q;
      ev = (u - t + Q) % Q;
    end else begin
      eu = (u + v) % Q;
      ev = (((u - v + Q) % Q) * wt) % Q;
    end
  endfunction

  task automatic drive(input bit v, input bit m, input int u, input int vv, input int w,
                       input int tag, input bit push, input int eu, input int ev);
    exp_t e;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = v; in_mode = m;
    in_u = W'(u); in_v = W'(vv); in_w = W'(w); in_tag = TW'(tag);
    if (v && push) begin
      e = '{eu, ev, tag & 255, cyc + LAT};
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 0, 0);
  endtask

  task automatic tick_rst(input bit r, input bit v);
    @(posedge clk); #1;
    rst = r; in_valid = v; in_mode = 1'($urandom_range(0, 1));
    in_u = W'($urandom_range(0, Q - 1)); in_v = W'($urandom_range(0, Q - 1));
    in_w = W'($urandom_range(0, Q - 1)); in_tag = TW'($urandom_range(0, 255));
  endtask

  // Monitor: pops the scoreboard on every out_valid, checks hold/reset otherwise.
  initial begin
    exp_t e;
    int hu, hv, ht;
    hu = 0; hv = 0; ht = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        check("reset_valid", int'(out_valid), 0);
        check("reset_u", int'(out_u), 0);
        check("reset_v", int'(out_v), 0);
        check("reset_tag", int'(out_tag), 0);
        hu = 0; hv = 0; ht = 0;
      end else if (out_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: out_valid=1 tag=%0d but none expected (cycle %0d)",
                   out_tag, cyc);
        end else begin
          e = sb.pop_front();
          check("out_cycle", cyc, e.at);
          check("out_u", int'(out_u), e.u);
          check("out_v", int'(out_v), e.v);
          check("out_tag", int'(out_tag), e.tag);
          hu = e.u; hv = e.v; ht = e.tag;
        end
      end else begin
        check("hold_u", int'(out_u), hu);
        check("hold_v", int'(out_v), hv);
        check("hold_tag", int'(out_tag), ht);
      end
    end
  end

  initial begin
    int eu, ev, u, v, w, tag, sent;
    bit m;
    for (int x = 1; x < Q; x++) if (((x << W) % Q) == 1) rinv = x;

    // Reset with in_valid high, then idle
    for (int i = 0; i < 3; i++) tick_rst(1'b1, 1'b1);
    tick_rst(1'b0, 1'b0);
    idle(19);

    // CT, zero twiddle: single isolated pulse
    drive(1, 0, 100, 200, 0, 5, 1, 100, 100);
    idle(16);

    // CT, identity twiddle
    drive(1, 0, 3000, 500, 767, 10, 1, 171, 2500);
    drive(1, 0, 10, 20, 767, 11, 1, 30, 3319);
    drive(1, 0, 3328, 3328, 767, 12, 1, 3327, 0);
    // GS, identity twiddle
    drive(1, 1, 3000, 500, 767, 20, 1, 171, 2500);
    drive(1, 1, 5, 9, 767, 21, 1, 14, 3325);
    drive(1, 1, 0, 0, 767, 22, 1, 0, 0);
    idle(LAT + 4);

    // Random stream with ~30% bubbles and incrementing tags
    sent = 0; tag = 0;
    while (sent < 256) begin
      if ($urandom_range(0, 99) < 30) begin
        idle(1);
      end else begin
        m = 1'($urandom_range(0, 1));
        u = int'($urandom_range(0, Q - 1));
        v = int'($urandom_range(0, Q - 1));
        w = int'($urandom_range(0, Q - 1));
        model(m, u, v, w, eu, ev);
        drive(1, m, u, v, w, tag, 1, eu, ev);
        tag = (tag + 1) & 255;
        sent++;
      end
    end
    idle(LAT + 4);

    // Reset mid-stream: in-flight samples must vanish
    for (int i = 0; i < 5; i++) drive(1, 0, 100 + i, 7, 767, 100 + i, 0, 0, 0);
    idle(2);
    tick_rst(1'b1, 1'b1);
    drive(1, 1, 1000, 2000, 767, 77, 1, 3000, 2329);
    idle(LAT + 6);

    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++; errors++;
      $display("FAIL missing_output: tag %0d expected at cycle %0d never appeared", e.tag, e.at);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
